// File: rtl/key_schedule_serial_pkg.sv
// Shared AES-128 key-schedule types and constants.
// Provides state_t, rcon constants and GF(2^8) xtime.
package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;
  localparam int         KEY_BYTES = 16;

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^
           (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_serial_if.sv
// Load and key-stream handshake bundle for key_schedule_serial.
// slave: the key generator; master: key source + key consumer.
interface key_schedule_serial_if;

  logic       io_loadValid;
  logic       io_loadReady;
  logic [7:0] io_keyIn;
  logic       io_keyValid;
  logic       io_keyReady;
  logic [7:0] io_keyOut;
  logic [3:0] io_round;
  logic       io_last;

  modport slave (
    input  io_loadValid,
    input  io_keyIn,
    input  io_keyReady,
    output io_loadReady,
    output io_keyValid,
    output io_keyOut,
    output io_round,
    output io_last
  );

  modport master (
    output io_loadValid,
    output io_keyIn,
    output io_keyReady,
    input  io_loadReady,
    input  io_keyValid,
    input  io_keyOut,
    input  io_round,
    input  io_last
  );

endinterface

// File: rtl/key_schedule_serial_sbox.sv
// Combinational AES forward S-box, 8 bits in, 8 bits out.
// Ports: a (input byte), y (substituted byte).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [127:0] ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [127:0] row;

  assign row = ROWS[a[7:4]];
  // Column 0 is the leftmost byte of each row.
  assign y   = row[{~a[3:0], 3'b000} +: 8];

endmodule

// File: rtl/key_schedule_serial.sv
// Byte-serial AES-128 round-key generator (rounds 0..NUM_ROUNDS).
// Ports: clock, reset (sync, active-high), io (slave handshake).
module key_schedule_serial
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input logic                 clock,
  input logic                 reset,
  key_schedule_serial_if.slave io
);

  localparam logic [3:0] LAST_R = 4'(NUM_ROUNDS);

  state_t     state_q, state_d;
  logic [7:0] key_q [KEY_BYTES];
  logic [7:0] key_d [KEY_BYTES];
  logic [3:0] j_q, j_d;
  logic [3:0] r_q, r_d;
  logic [7:0] rcon_q, rcon_d;

  logic [7:0] sbox_in;
  logic [7:0] sbox_out;
  logic [7:0] new_byte;
  logic       xfer;
  logic       last;

  // One S-box: bytes 0..2 of a word use the
  // rotated tail, byte 3 wraps to w3[0] at 9.
  assign sbox_in = (j_q == 4'd3) ? key_q[9]
                                 : key_q[13];

  aes_sbox u_sbox (
    .a (sbox_in),
    .y (sbox_out)
  );

  always_comb begin
    new_byte = key_q[0];
    if (j_q < 4'd4)
      new_byte = new_byte ^ sbox_out;
    else
      new_byte = new_byte ^ key_q[12];
    if (j_q == 4'd0)
      new_byte = new_byte ^ rcon_q;
  end

  assign xfer = (state_q == RUN) && io.io_keyReady;
  assign last = (state_q == RUN) &&
                (r_q == LAST_R) &&
                (j_q == 4'd15);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    j_d     = j_q;
    r_d     = r_q;
    rcon_d  = rcon_q;
    unique case (state_q)
      LOAD: begin
        if (io.io_loadValid) begin
          for (int i = 0; i < KEY_BYTES - 1; i++)
            key_d[i] = key_q[i+1];
          key_d[KEY_BYTES-1] = io.io_keyIn;
          j_d = j_q + 4'd1;
          if (j_q == 4'd15) begin
            j_d     = 4'd0;
            r_d     = 4'd0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (xfer && last) begin
          for (int i = 0; i < KEY_BYTES; i++)
            key_d[i] = 8'h00;
          j_d     = 4'd0;
          r_d     = 4'd0;
          rcon_d  = RCON_INIT;
          state_d = LOAD;
        end else if (xfer) begin
          for (int i = 0; i < KEY_BYTES - 1; i++)
            key_d[i] = key_q[i+1];
          key_d[KEY_BYTES-1] = new_byte;
          j_d = j_q + 4'd1;
          if (j_q == 4'd15) begin
            r_d    = r_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LOAD;
      for (int i = 0; i < KEY_BYTES; i++)
        key_q[i] <= 8'h00;
      j_q    <= 4'd0;
      r_q    <= 4'd0;
      rcon_q <= RCON_INIT;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < KEY_BYTES; i++)
        key_q[i] <= key_d[i];
      j_q    <= j_d;
      r_q    <= r_d;
      rcon_q <= rcon_d;
    end
  end

  assign io.io_loadReady = (state_q == LOAD);
  assign io.io_keyValid  = (state_q == RUN);
  assign io.io_keyOut    = key_q[0];
  assign io.io_round     = r_q;
  assign io.io_last      = last;

endmodule

// File: tb/tb_key_schedule_serial.sv
// Directed bench for key_schedule_serial.
// FIPS-197 round keys checked byte-serially.
module tb_key_schedule_serial;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  key_schedule_serial_if io ();

  key_schedule_serial #(
    .NUM_ROUNDS (10)
  ) dut (
    .clock (clk),
    .reset (rst),
    .io    (io)
  );

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] KEY_STD =
    128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [127:0] rk_std [11];
  logic [127:0] rk_zero [3];
  logic [127:0] exp_rk [11];

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic load_key(
    input logic [127:0] key,
    input bit           gaps
  );
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        for (int g = 0; g < i % 3; g++) begin
          io.io_loadValid = 1'b0;
          io.io_keyIn     = 8'($urandom);
          @(negedge clk);
        end
      end
      if (i == 15) begin
        chk("pre16_valid", 128'(io.io_keyValid), 0);
        chk("pre16_lrdy", 128'(io.io_loadReady), 1);
      end
      io.io_loadValid = 1'b1;
      io.io_keyIn     = key[127-8*i -: 8];
      @(negedge clk);
    end
    io.io_loadValid = 1'b0;
    chk("first_valid", 128'(io.io_keyValid), 1);
    chk("first_byte", 128'(io.io_keyOut),
        128'(key[127:120]));
  endtask

  task automatic stream(
    input bit rnd,
    input bit poke,
    input int stop,
    input int ncheck
  );
    logic [127:0] acc = '0;
    int n = 0;
    int cyc = 0;
    int lasts = 0;
    int last_at = -1;
    int bad_rnd = 0;
    int bad_hold = 0;
    bit pend = 1'b0;
    bit rdy;
    logic [7:0] pk = '0;
    logic [3:0] pr = '0;
    while (n < stop && cyc < 4000) begin
      if (pend && (io.io_keyOut !== pk ||
                   io.io_round !== pr))
        bad_hold++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      io.io_keyReady  = rdy;
      io.io_loadValid = poke ? 1'($urandom) : 1'b0;
      io.io_keyIn     = 8'($urandom);
      if (io.io_keyValid && rdy) begin
        if (io.io_round !== 4'(n / 16))
          bad_rnd++;
        acc = {acc[119:0], io.io_keyOut};
        if (io.io_last) begin
          lasts++;
          last_at = n;
        end
        n++;
        if (n % 16 == 0 && n / 16 <= ncheck)
          chk($sformatf("rk%0d", n / 16 - 1),
              acc, exp_rk[n/16-1]);
        pend = 1'b0;
      end else begin
        pend = io.io_keyValid;
        pk   = io.io_keyOut;
        pr   = io.io_round;
      end
      @(negedge clk);
      cyc++;
    end
    io.io_keyReady  = 1'b0;
    io.io_loadValid = 1'b0;
    chk("xfers", 128'(n), 128'(stop));
    chk("round_idx", 128'(bad_rnd), 0);
    chk("hold", 128'(bad_hold), 0);
    if (stop == 176) begin
      chk("last_cnt", 128'(lasts), 1);
      chk("last_pos", 128'(last_at), 175);
      chk("end_lrdy", 128'(io.io_loadReady), 1);
      chk("end_valid", 128'(io.io_keyValid), 0);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_lrdy"}, 128'(io.io_loadReady), 1);
    chk({tag, "_valid"}, 128'(io.io_keyValid), 0);
    chk({tag, "_out"}, 128'(io.io_keyOut), 0);
    chk({tag, "_round"}, 128'(io.io_round), 0);
    chk({tag, "_last"}, 128'(io.io_last), 0);
  endtask

  initial begin
    rk_std[0]  = KEY_STD;
    rk_std[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_std[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_std[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_std[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_std[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_std[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_std[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_std[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_std[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_std[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rk_zero[0] = '0;
    rk_zero[1] = 128'h62636363626363636263636362636363;
    rk_zero[2] = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

    io.io_loadValid = 1'b0;
    io.io_keyIn     = 8'h00;
    io.io_keyReady  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle("rst");

    // Full run, continuous ready.
    for (int i = 0; i < 11; i++)
      exp_rk[i] = rk_std[i];
    load_key(KEY_STD, 1'b0);
    stream(1'b0, 1'b0, 176, 11);

    // Random backpressure.
    load_key(KEY_STD, 1'b0);
    stream(1'b1, 1'b0, 176, 11);

    // All-zero key.
    for (int i = 0; i < 3; i++)
      exp_rk[i] = rk_zero[i];
    load_key('0, 1'b0);
    stream(1'b0, 1'b0, 176, 3);

    // Abort at r=4, j=7.
    for (int i = 0; i < 11; i++)
      exp_rk[i] = rk_std[i];
    load_key(KEY_STD, 1'b0);
    stream(1'b0, 1'b0, 71, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("abort");
    load_key(KEY_STD, 1'b0);
    stream(1'b0, 1'b0, 176, 11);

    // Gapped load, loadValid noise in RUN.
    load_key(KEY_STD, 1'b1);
    stream(1'b1, 1'b1, 176, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
